// File: rtl/stopwatch_control_if.sv
// Button/tick inputs and timer/display outputs of the stopwatch controller.
interface stopwatch_control_if;
   logic       start_stop_pulse;
   logic       lap_pulse;
   logic       clear_pulse;
   logic       tick_10ms;
   logic       timer_enabled;
   logic       timer_clear;
   logic [3:0] disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_hs_t, disp_hs_o;
   logic       running;
   logic       lap_active;
   logic       overflow;

   modport master (
      output start_stop_pulse, lap_pulse, clear_pulse, tick_10ms,
      input  timer_enabled, timer_clear, running, lap_active, overflow,
      input  disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_hs_t, disp_hs_o
   );

   modport slave (
      input  start_stop_pulse, lap_pulse, clear_pulse, tick_10ms,
      output timer_enabled, timer_clear, running, lap_active, overflow,
      output disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_hs_t, disp_hs_o
   );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch run/lap/stop FSM with MM:SS.hh BCD accumulator and lap freeze.
module stopwatch_control #(
   parameter int MINUTE_LIMIT        = 60,
   parameter int TICKS_PER_HUNDREDTH = 1
) (
   input  logic             clk,
   input  logic             sync_reset,
   stopwatch_control_if.slave sw
);
   typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

   typedef struct packed {
      logic [3:0] min_t, min_o, sec_t, sec_o, hs_t, hs_o;
   } bcd_time_t;

   localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_HUNDREDTH - 1);
   localparam logic [6:0] MIN_LIM   = 7'(MINUTE_LIMIT);

   state_t    state, state_nxt;
   bcd_time_t live, lap_q, live_inc, disp;
   logic [7:0] presc;
   logic [6:0] min_bin_nxt;
   logic      overflow_q, wrap, count_en;

   always_ff @(posedge clk) begin
      if (sync_reset) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sw.start_stop_pulse) state_nxt = RUN;
         RUN:     if (sw.start_stop_pulse) state_nxt = STOP;
                  else if (sw.lap_pulse)   state_nxt = LAP;
         LAP:     if (sw.start_stop_pulse) state_nxt = STOP;
                  else if (sw.lap_pulse)   state_nxt = RUN;
         STOP:    if (sw.clear_pulse)      state_nxt = IDLE;
                  else if (sw.start_stop_pulse) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_en         = (state == RUN) || (state == LAP);
      sw.timer_enabled = count_en;
      sw.running       = count_en;
      sw.timer_clear   = (state == IDLE);
      sw.lap_active    = (state == LAP);
   end

   // Full carry chain in one cycle; the minute roll is checked against the wrap limit.
   always_comb begin
      live_inc    = live;
      wrap        = 1'b0;
      min_bin_nxt = 7'(live.min_t) * 7'd10 + 7'(live.min_o) + 7'd1;
      if (live.hs_o != 4'd9) live_inc.hs_o = live.hs_o + 4'd1;
      else begin
         live_inc.hs_o = 4'd0;
         if (live.hs_t != 4'd9) live_inc.hs_t = live.hs_t + 4'd1;
         else begin
            live_inc.hs_t = 4'd0;
            if (live.sec_o != 4'd9) live_inc.sec_o = live.sec_o + 4'd1;
            else begin
               live_inc.sec_o = 4'd0;
               if (live.sec_t != 4'd5) live_inc.sec_t = live.sec_t + 4'd1;
               else begin
                  live_inc.sec_t = 4'd0;
                  if (min_bin_nxt == MIN_LIM) begin
                     live_inc = '0;
                     wrap     = 1'b1;
                  end else if (live.min_o != 4'd9) begin
                     live_inc.min_o = live.min_o + 4'd1;
                  end else begin
                     live_inc.min_o = 4'd0;
                     live_inc.min_t = live.min_t + 4'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset || (state == STOP && sw.clear_pulse)) begin
         live       <= '0;
         lap_q      <= '0;
         presc      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (count_en && sw.tick_10ms) begin
            if (presc == PRESC_MAX) begin
               presc <= '0;
               live  <= live_inc;
               if (wrap) overflow_q <= 1'b1;
            end else begin
               presc <= presc + 8'd1;
            end
         end
         // Lap captures the pre-increment value seen at the same edge.
         if (state == RUN && sw.lap_pulse && !sw.start_stop_pulse) lap_q <= live;
      end
   end

   always_comb begin
      disp          = (state == LAP) ? lap_q : live;
      sw.disp_min_t = disp.min_t;
      sw.disp_min_o = disp.min_o;
      sw.disp_sec_t = disp.sec_t;
      sw.disp_sec_o = disp.sec_o;
      sw.disp_hs_t  = disp.hs_t;
      sw.disp_hs_o  = disp.hs_o;
      sw.overflow   = overflow_q;
   end
endmodule

// File: tb/tb_stopwatch_control.sv
// Directed scoreboard bench for stopwatch_control across three parameter sets.
module tb_stopwatch_control;
   logic clk = 1'b0;
   logic sync_reset;
   always #5 clk = ~clk;

   stopwatch_control_if if_a ();
   stopwatch_control_if if_b ();
   stopwatch_control_if if_c ();

   stopwatch_control u_a (.clk(clk), .sync_reset(sync_reset), .sw(if_a.slave));
   stopwatch_control #(.MINUTE_LIMIT(2)) u_b (.clk(clk), .sync_reset(sync_reset), .sw(if_b.slave));
   stopwatch_control #(.TICKS_PER_HUNDREDTH(4)) u_c (.clk(clk), .sync_reset(sync_reset), .sw(if_c.slave));

   typedef struct {
      string       tag;
      logic [28:0] val;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // flags order: timer_enabled, timer_clear, running, lap_active
   localparam logic [3:0] F_IDLE = 4'b0100;
   localparam logic [3:0] F_RUN  = 4'b1010;
   localparam logic [3:0] F_LAP  = 4'b1011;
   localparam logic [3:0] F_STOP = 4'b0000;

   function automatic logic [28:0] obs(input int sel);
      logic [28:0] o;
      case (sel)
         0: o = {if_a.disp_min_t, if_a.disp_min_o, if_a.disp_sec_t, if_a.disp_sec_o,
                 if_a.disp_hs_t, if_a.disp_hs_o, if_a.timer_enabled, if_a.timer_clear,
                 if_a.running, if_a.lap_active, if_a.overflow};
         1: o = {if_b.disp_min_t, if_b.disp_min_o, if_b.disp_sec_t, if_b.disp_sec_o,
                 if_b.disp_hs_t, if_b.disp_hs_o, if_b.timer_enabled, if_b.timer_clear,
                 if_b.running, if_b.lap_active, if_b.overflow};
         default: o = {if_c.disp_min_t, if_c.disp_min_o, if_c.disp_sec_t, if_c.disp_sec_o,
                 if_c.disp_hs_t, if_c.disp_hs_o, if_c.timer_enabled, if_c.timer_clear,
                 if_c.running, if_c.lap_active, if_c.overflow};
      endcase
      return o;
   endfunction

   task automatic expect_state(input string tag, input logic [23:0] d,
                               input logic [3:0] f, input logic ovf);
      exp_t e;
      e.tag = tag;
      e.val = {d, f, ovf};
      q.push_back(e);
   endtask

   task automatic check(input int sel);
      exp_t e;
      logic [28:0] o;
      e = q.pop_front();
      o = obs(sel);
      checks++;
      assert (o === e.val) else begin
         errors++;
         $error("FAIL %s: observed digits=%h flags=%b ovf=%b, expected digits=%h flags=%b ovf=%b",
                e.tag, o[28:5], o[4:1], o[0], e.val[28:5], e.val[4:1], e.val[0]);
      end
   endtask

   task automatic idle_inputs();
      if_a.start_stop_pulse = 0; if_a.lap_pulse = 0; if_a.clear_pulse = 0; if_a.tick_10ms = 0;
      if_b.start_stop_pulse = 0; if_b.lap_pulse = 0; if_b.clear_pulse = 0; if_b.tick_10ms = 0;
      if_c.start_stop_pulse = 0; if_c.lap_pulse = 0; if_c.clear_pulse = 0; if_c.tick_10ms = 0;
   endtask

   // Apply inputs for one edge, then sample 1 ns after it.
   task automatic drive(input int sel, input bit ss, input bit lp, input bit clr, input bit tk);
      case (sel)
         0: begin if_a.start_stop_pulse = ss; if_a.lap_pulse = lp; if_a.clear_pulse = clr; if_a.tick_10ms = tk; end
         1: begin if_b.start_stop_pulse = ss; if_b.lap_pulse = lp; if_b.clear_pulse = clr; if_b.tick_10ms = tk; end
         default: begin if_c.start_stop_pulse = ss; if_c.lap_pulse = lp; if_c.clear_pulse = clr; if_c.tick_10ms = tk; end
      endcase
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic ticks(input int sel, input int n);
      for (int i = 0; i < n; i++) drive(sel, 0, 0, 0, 1);
   endtask

   initial begin
      idle_inputs();
      sync_reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      sync_reset = 1'b0;
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
      expect_state("reset_a", 24'h000000, F_IDLE, 0); check(0);
      expect_state("reset_c", 24'h000000, F_IDLE, 0); check(2);

      // Basic run/stop
      drive(0, 1, 0, 0, 0);
      expect_state("start", 24'h000000, F_RUN, 0); check(0);
      ticks(0, 123);
      expect_state("run_123", 24'h000123, F_RUN, 0); check(0);
      drive(0, 1, 0, 0, 0);
      expect_state("stop", 24'h000123, F_STOP, 0); check(0);
      ticks(0, 10);
      expect_state("stop_ticks", 24'h000123, F_STOP, 0); check(0);

      // Clear beats start_stop in STOP
      drive(0, 1, 0, 1, 0);
      expect_state("clear_ss", 24'h000000, F_IDLE, 0); check(0);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      expect_state("clear_in_run", 24'h000001, F_RUN, 0); check(0);

      // Lap freeze
      ticks(0, 999);
      expect_state("at_10s", 24'h001000, F_RUN, 0); check(0);
      drive(0, 0, 1, 0, 0);
      expect_state("lap_enter", 24'h001000, F_LAP, 0); check(0);
      ticks(0, 50);
      expect_state("lap_hold", 24'h001000, F_LAP, 0); check(0);
      drive(0, 0, 1, 0, 0);
      expect_state("lap_exit", 24'h001050, F_RUN, 0); check(0);

      // Minute carry
      ticks(0, 4949);
      expect_state("at_59_99", 24'h005999, F_RUN, 0); check(0);
      ticks(0, 1);
      expect_state("min_carry", 24'h010000, F_RUN, 0); check(0);

      // Lap with coincident tick captures pre-tick value; stop from LAP shows live
      drive(0, 0, 1, 0, 1);
      expect_state("lap_tick", 24'h010000, F_LAP, 0); check(0);
      drive(0, 1, 0, 0, 0);
      expect_state("lap_to_stop", 24'h010001, F_STOP, 0); check(0);
      drive(0, 0, 1, 0, 0);
      expect_state("stop_lap_ign", 24'h010001, F_STOP, 0); check(0);
      drive(0, 1, 0, 0, 1);
      expect_state("resume_tick_ign", 24'h010001, F_RUN, 0); check(0);
      drive(0, 1, 0, 0, 1);
      expect_state("stop_tick_cnt", 24'h010002, F_STOP, 0); check(0);

      // Wrap with MINUTE_LIMIT=2
      drive(1, 1, 0, 0, 0);
      ticks(1, 11999);
      expect_state("b_1_59_99", 24'h015999, F_RUN, 0); check(1);
      ticks(1, 1);
      expect_state("b_wrap", 24'h000000, F_RUN, 1); check(1);
      ticks(1, 5);
      expect_state("b_sticky", 24'h000005, F_RUN, 1); check(1);
      drive(1, 1, 0, 0, 0);
      expect_state("b_stop", 24'h000005, F_STOP, 1); check(1);
      drive(1, 0, 0, 1, 0);
      expect_state("b_clear", 24'h000000, F_IDLE, 0); check(1);

      // Prescaler with TICKS_PER_HUNDREDTH=4
      drive(2, 1, 0, 0, 1);
      ticks(2, 3);
      expect_state("c_3_ticks", 24'h000000, F_RUN, 0); check(2);
      ticks(2, 5);
      expect_state("c_8_ticks", 24'h000002, F_RUN, 0); check(2);

      // Reset mid-run overrides pulses
      drive(0, 1, 0, 0, 0);
      if_a.start_stop_pulse = 1; if_a.tick_10ms = 1; if_a.lap_pulse = 1;
      sync_reset = 1'b1;
      @(posedge clk); #1;
      sync_reset = 1'b0;
      idle_inputs();
      expect_state("mid_reset", 24'h000000, F_IDLE, 0); check(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stopwatch_control.md
Name: stopwatch_control

Overview:
- Control FSM and BCD time accumulator for the stopwatch.
- Turns single-cycle button pulses (start/stop, lap, clear) into the timer's enabled/clear controls.
- Counts the timer's 10 ms tick into MM:SS.hh BCD digits and provides lap-freeze of the displayed value.
- Sits between the debounced button logic and the timer, and drives the 7-segment display mux.

Parameters:
- MINUTE_LIMIT, 60, minute count at which time wraps to 00:00.00 (legal 1..99)
- TICKS_PER_HUNDREDTH, 1, number of tick_10ms pulses per hundredth increment (legal 1..255)

Ports:
- clk  input  1  system clock
- sync_reset  input  1  synchronous active-high reset
- start_stop_pulse  input  1  one-cycle pulse, toggles run/stop
- lap_pulse  input  1  one-cycle pulse, toggles lap freeze
- clear_pulse  input  1  one-cycle pulse, zeroes time (honoured only when stopped)
- tick_10ms  input  1  one-cycle pulse from timer elapsed_10ms
- timer_enabled  output  1  drives timer enabled
- timer_clear  output  1  drives timer clear
- disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_hs_t, disp_hs_o  output  4 each  displayed BCD digits
- running  output  1  high in RUN or LAP
- lap_active  output  1  high in LAP
- overflow  output  1  sticky wrap flag

Behaviour:
- Single clock `clk`. Reset is synchronous and active-high on `sync_reset`, with priority over all inputs.
- Reset values:
  - state = IDLE
  - live and lap digits = 0
  - tick prescaler = 0
  - overflow = 0
  - timer_enabled = 0, timer_clear = 1, running = 0, lap_active = 0
- States: IDLE, RUN, LAP, STOP. Inputs per state, in priority order clear > start_stop > lap; lower-priority pulses in the same cycle are ignored.
  - IDLE: start_stop -> RUN; lap and clear are ignored.
  - RUN: start_stop -> STOP; lap -> LAP, and lap regs load the current live digits at the same edge; clear is ignored.
  - LAP: start_stop -> STOP, display returns to live; lap -> RUN, display returns to live; clear is ignored.
  - STOP: clear -> IDLE, zeroing live digits, lap regs, prescaler and overflow; start_stop -> RUN, resuming from the held value; lap is ignored.
- Control outputs are combinational from state:
  - timer_enabled = running = (state is RUN or LAP)
  - timer_clear = (state is IDLE)
  - lap_active = (state is LAP)
- Display digits: lap regs when in LAP, otherwise live digits.
- Counting occurs only while the state register is RUN or LAP.
  - A tick_10ms in that cycle increments the prescaler.
  - When the prescaler reaches TICKS_PER_HUNDREDTH-1, it resets to 0 and the hundredths advance by 1 at that edge (one cycle latency from tick to digit).
  - A tick in the same cycle as a RUN->STOP transition is counted.
  - A tick in the same cycle as a STOP->RUN or IDLE->RUN transition is ignored.
- BCD carry chain, all carries resolved in one cycle:
  - hs ones 9 -> 0 carries into hs tens
  - hs tens 9 -> 0 carries into sec ones
  - sec ones 9 -> 0 carries into sec tens
  - sec tens 5 -> 0 carries into minutes
  - minutes count in BCD
- Wrap: when the increment would make minutes equal MINUTE_LIMIT, all live digits become 0, overflow is set, and counting continues.
- overflow is sticky; only clear-to-IDLE or reset drops it.
- Lap regs are unchanged by ticks.
- Reset mid-run: the next edge returns to IDLE with all values zero regardless of the pulses present.

Test Plan:
- Reset, then 5 idle cycles -> timer_clear=1, timer_enabled=0, all digits 0, overflow=0.
- start_stop, then 123 tick_10ms pulses, then start_stop -> state STOP, display 00:01.23, timer_enabled=0; a further 10 ticks leave 00:01.23.
- Running from 00:59.99 with one tick -> 01:00.00 one cycle after the tick. With MINUTE_LIMIT=2 at 01:59.99, one tick -> 00:00.00 and overflow=1; overflow stays 1 until STOP+clear.
- At 00:10.00 in RUN, lap, then 50 ticks -> display holds 00:10.00 with lap_active=1. Then lap -> display 00:10.50 and lap_active=0.
- In RUN, clear pulse -> ignored, counting continues. In STOP, clear with start_stop in the same cycle -> IDLE, digits 0, timer_clear=1.
- TICKS_PER_HUNDREDTH=4, 8 ticks while running -> 00:00.02. A tick coincident with IDLE->start_stop is not counted.
